cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Synthesisable run controller for the pipelined CPU core. It generates a sequenced core reset, counts cycles and retired instructions, and ends a run on halt or watchdog timeout. It can optionally auto-restart the core for repeated runs. It sits between the board/bench clock-reset and the CPU top, generalising the fixed 2-cycle reset, 20-cycle run and 8-bit cycle count into parametrised, observable hardware.

Parameters:
CNT_W, 16, width of cycle_cnt and instr_cnt (min 4)
RST_CYCLES, 2, cycles core_rst is held high per run (min 1)
MAX_CYCLES, 20, watchdog limit on RUN cycles; 0 disables the watchdog
AUTO_RESTART, 0, 1 = re-enter RESET automatically after DONE; 0 = wait for start
RUN_W, 8, width of run_cnt

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-low reset (asserted when 0)
start  in  1  begin a run; sampled in IDLE and DONE
hlt  in  1  CPU halt indication; sampled in RUN only
retire  in  1  one instruction retired this cycle; sampled in RUN only
core_rst  out  1  active-high synchronous reset to the CPU core
running  out  1  high while in RUN
done  out  1  high while in DONE
timeout  out  1  high in DONE when the run ended by watchdog, not hlt
cycle_cnt  out  CNT_W  cycles spent in RUN for the current/last run
instr_cnt  out  CNT_W  retire pulses counted in the current/last run
run_cnt  out  RUN_W  number of completed runs, wraps
stall_cnt  out  CNT_W  see Optional Feature

Behaviour:
- One clock. All state uses asynchronous active-low reset on rst; everything else is synchronous to clk.
- Reset values: state=IDLE, core_rst=1, running=0, done=0, timeout=0, all counters=0.
- States: IDLE, RESET, RUN, DONE. All outputs are registered; no combinational input-to-output path.
- IDLE: core_rst=1. On start=1, go to RESET and clear cycle_cnt, instr_cnt and stall_cnt.
- RESET: core_rst=1 for exactly RST_CYCLES cycles, tracked by an internal down-counter. Then go to RUN; core_rst deasserts in the same cycle running asserts.
- RUN: core_rst=0. cycle_cnt increments every cycle; instr_cnt increments when retire=1. Both counters saturate at all-ones (no wrap).
- End of run, evaluated each RUN cycle:
  - hlt=1: go to DONE with timeout=0.
  - Otherwise, if MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1: go to DONE with timeout=1.
  - hlt and watchdog in the same cycle: hlt wins, timeout=0.
  - retire in the final RUN cycle is counted.
- Entering DONE: run_cnt increments (wraps at 2^RUN_W); core_rst=1; counters freeze and hold until the next RESET entry.
- DONE, AUTO_RESTART=0: stay until start=1, then go to RESET.
- DONE, AUTO_RESTART=1: after one cycle in DONE, go to RESET regardless of start.
- start is ignored in RESET and RUN.
- Asynchronous reset mid-run returns immediately to the reset values, including run_cnt=0.
- timeout clears on entry to RESET.

Optional Feature:
Macro: CPU_RUN_CTRL_STALL_STATS_EN.
- Defined: stall_cnt counts RUN cycles with retire=0. It saturates, clears on RESET entry, and freezes in DONE. Invariant in DONE: cycle_cnt == instr_cnt + stall_cnt when no counter has saturated.
- Undefined: stall_cnt is constant 0 and no counter register is built.

Test Plan:
1. Defaults; release rst, start pulse, hlt held 0, retire=1 every cycle -> core_rst high 2 cycles, then RUN for 20 cycles; DONE with timeout=1, cycle_cnt=20, instr_cnt=20, run_cnt=1.
2. MAX_CYCLES=0, hlt=1 on the 7th RUN cycle, retire on alternate cycles starting with the 1st -> DONE, timeout=0, cycle_cnt=7, instr_cnt=4; with the macro defined, stall_cnt=3.
3. hlt=1 exactly on the 20th RUN cycle -> DONE with timeout=0 (hlt priority), cycle_cnt=20.
4. AUTO_RESTART=1, hlt never asserted -> three back-to-back runs each of 2 RESET + 20 RUN + 1 DONE cycles; run_cnt reads 3 after the third DONE; no start needed after the first.
5. CNT_W=4, MAX_CYCLES=0, retire=1 for 30 cycles then hlt -> cycle_cnt=15, instr_cnt=15 (saturated, no wrap).
6. Assert rst (low) on the 5th RUN cycle -> the same cycle shows core_rst=1, running=0, all counters 0, state IDLE; a later start yields a clean run.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the pipelined CPU core.
// Sequences the core reset, runs the core until halt or watchdog expiry,
// counts RUN cycles, retired instructions and completed runs.
// Optional stall statistics are built when CPU_RUN_CTRL_STALL_STATS_EN is defined;
// otherwise stall_cnt is tied to zero.
module cpu_run_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned MAX_CYCLES   = 20,
  parameter int unsigned AUTO_RESTART = 0,
  parameter int unsigned RUN_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hlt,
  input  logic             retire,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [RUN_W-1:0] run_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned     RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam bit              WD_EN   = (MAX_CYCLES != 0);
  localparam bit              AUTO_EN = (AUTO_RESTART != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RC_W-1:0]  r_rst_cnt;
  logic             r_core_rst;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [RUN_W-1:0] r_run_cnt;

  logic w_wdog;
  logic w_core_rst_nxt;
  logic w_running_nxt;
  logic w_done_nxt;
  logic w_timeout_nxt;
  logic w_enter_reset;
  logic w_enter_done;

  // Watchdog fires on the last permitted RUN cycle
  assign w_wdog = WD_EN && (r_cycle_cnt == WD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; hlt takes priority over the watchdog
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RESET;
      S_RESET: if (r_rst_cnt == '0) w_state_nxt = S_RUN;
      S_RUN:   if (hlt || w_wdog) w_state_nxt = S_DONE;
      S_DONE:  if (AUTO_EN || start) w_state_nxt = S_RESET;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    w_core_rst_nxt = 1'b1;
    w_running_nxt  = 1'b0;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_enter_reset  = 1'b0;
    w_enter_done   = 1'b0;
    case (w_state_nxt)
      S_RUN: begin
        w_core_rst_nxt = 1'b0;
        w_running_nxt  = 1'b1;
      end
      S_DONE: begin
        w_done_nxt    = 1'b1;
        w_enter_done  = (r_state == S_RUN);
        w_timeout_nxt = (r_state == S_RUN) ? ~hlt : r_timeout;
      end
      S_RESET: w_enter_reset = (r_state != S_RESET);
      default: ;
    endcase
  end

  // Output flags and reset-length down-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_rst <= 1'b1;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rst_cnt  <= '0;
    end else begin
      r_core_rst <= w_core_rst_nxt;
      r_running  <= w_running_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_enter_reset)
        r_rst_cnt <= RC_LOAD;
      else if ((r_state == S_RESET) && (r_rst_cnt != '0))
        r_rst_cnt <= r_rst_cnt - RC_W'(1);
    end
  end

  // Saturating cycle/instruction counters and wrapping run counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
      r_run_cnt   <= '0;
    end else begin
      if (w_enter_reset) begin
        r_cycle_cnt <= '0;
        r_instr_cnt <= '0;
      end else if (r_state == S_RUN) begin
        if (r_cycle_cnt != '1)           r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        if (retire && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
      if (w_enter_done) r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end

`ifdef CPU_RUN_CTRL_STALL_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of RUN cycles without a retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_enter_reset)
      r_stall_cnt <= '0;
    else if ((r_state == S_RUN) && !retire && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign core_rst  = r_core_rst;
  assign running   = r_running;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
  assign run_cnt   = r_run_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: three instances (default, 4-bit saturating
// counters without watchdog, auto-restart) checked against a run-level model.
module tb_cpu_run_ctrl;

  localparam int RST_N = 2;

  logic clk = 1'b0;
  logic rst;
  logic start_m, start_s, start_a;
  logic hlt, retire;

  always #5 clk = ~clk;

  // default instance
  logic m_core_rst, m_running, m_done, m_timeout;
  logic [15:0] m_cyc, m_ins, m_stl;
  logic [7:0]  m_run;
  // saturation instance
  logic s_core_rst, s_running, s_done, s_timeout;
  logic [3:0] s_cyc, s_ins, s_stl;
  logic [7:0] s_run;
  // auto-restart instance
  logic a_core_rst, a_running, a_done, a_timeout;
  logic [15:0] a_cyc, a_ins, a_stl;
  logic [7:0]  a_run;

  cpu_run_ctrl u_main (
    .clk(clk), .rst(rst), .start(start_m), .hlt(hlt), .retire(retire),
    .core_rst(m_core_rst), .running(m_running), .done(m_done), .timeout(m_timeout),
    .cycle_cnt(m_cyc), .instr_cnt(m_ins), .run_cnt(m_run), .stall_cnt(m_stl)
  );

  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .hlt(hlt), .retire(retire),
    .core_rst(s_core_rst), .running(s_running), .done(s_done), .timeout(s_timeout),
    .cycle_cnt(s_cyc), .instr_cnt(s_ins), .run_cnt(s_run), .stall_cnt(s_stl)
  );

  cpu_run_ctrl #(.AUTO_RESTART(1)) u_auto (
    .clk(clk), .rst(rst), .start(start_a), .hlt(hlt), .retire(retire),
    .core_rst(a_core_rst), .running(a_running), .done(a_done), .timeout(a_timeout),
    .cycle_cnt(a_cyc), .instr_cnt(a_ins), .run_cnt(a_run), .stall_cnt(a_stl)
  );

  // Observation mux selecting the instance under test
  int sel = 0;
  logic [3:0]  o_flags;  // {core_rst, running, done, timeout}
  logic [15:0] o_cyc, o_ins, o_stl;
  logic [7:0]  o_run;
  always_comb begin
    o_flags = {m_core_rst, m_running, m_done, m_timeout};
    o_cyc = m_cyc; o_ins = m_ins; o_stl = m_stl; o_run = m_run;
    if (sel == 1) begin
      o_flags = {s_core_rst, s_running, s_done, s_timeout};
      o_cyc = 16'(s_cyc); o_ins = 16'(s_ins); o_stl = 16'(s_stl); o_run = s_run;
    end else if (sel == 2) begin
      o_flags = {a_core_rst, a_running, a_done, a_timeout};
      o_cyc = a_cyc; o_ins = a_ins; o_stl = a_stl; o_run = a_run;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_run[3];

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_m = v;
    else if (s == 1) start_s = v;
    else start_a = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run: model computes the outcome from hlt/retire vectors
  task automatic run_once(input string nm, input int s, input int max_c, input int cw,
                          input int hlt_at, input int mode);
    bit hv[1:64];
    bit rv[1:64];
    int end_k, ins, sat, ec, ei, es, pins;
    bit exp_to;
    for (int k = 1; k <= 64; k++) begin
      hv[k] = (k == hlt_at);
      case (mode)
        0:       rv[k] = 1'b0;
        1:       rv[k] = 1'b1;
        2:       rv[k] = (k % 2) == 1;
        default: rv[k] = 1'($urandom_range(0, 1));
      endcase
    end
    end_k = 0; exp_to = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (end_k == 0) begin
        if (hv[k]) end_k = k;
        else if (max_c != 0 && k == max_c) begin end_k = k; exp_to = 1'b1; end
      end
    end
    if (end_k == 0) end_k = 64;
    ins = 0;
    for (int k = 1; k <= end_k; k++) ins += int'(rv[k]);
    sat = (1 << cw) - 1;
    ec = (end_k < sat) ? end_k : sat;
    ei = (ins < sat) ? ins : sat;
`ifdef CPU_RUN_CTRL_STALL_STATS_EN
    es = ((end_k - ins) < sat) ? (end_k - ins) : sat;
`else
    es = 0;
`endif
    sel = s;
    set_start(s, 1'b1);
    tick();
    for (int r = 1; r <= RST_N; r++) begin
      set_start(s, (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      n_checks++;
      if (o_flags !== 4'b1000 || o_cyc !== 16'd0 || o_ins !== 16'd0 || o_stl !== 16'd0) begin
        n_fail++;
        $display("FAIL %s reset_phase r=%0d: flags=%b cyc=%0d ins=%0d stl=%0d, required flags=1000 counts 0",
                 nm, r, o_flags, o_cyc, o_ins, o_stl);
      end
      tick();
    end
    pins = 0;
    for (int k = 1; k <= end_k; k++) begin
      n_checks++;
      if (o_flags !== 4'b0100 || o_cyc !== 16'(((k - 1) < sat) ? (k - 1) : sat)
          || o_ins !== 16'((pins < sat) ? pins : sat)) begin
        n_fail++;
        $display("FAIL %s run_cycle k=%0d: flags=%b cyc=%0d ins=%0d, required flags=0100 cyc=%0d ins=%0d",
                 nm, k, o_flags, o_cyc, o_ins, k - 1, pins);
      end
      hlt = hv[k];
      retire = rv[k];
      pins += int'(rv[k]);
      if (mode == 3) set_start(s, 1'($urandom_range(0, 1)));
      tick();
    end
    hlt = 1'b0; retire = 1'b0;
    set_start(s, 1'b0);
    exp_run[s] = (exp_run[s] + 1) % 256;
    for (int h = 0; h < 2; h++) begin
      n_checks++;
      if (o_flags !== {3'b101, exp_to} || o_cyc !== 16'(ec) || o_ins !== 16'(ei)
          || o_stl !== 16'(es) || o_run !== 8'(exp_run[s])) begin
        n_fail++;
        $display("FAIL %s done h=%0d: flags=%b cyc=%0d ins=%0d stl=%0d run=%0d, required flags=101%b cyc=%0d ins=%0d stl=%0d run=%0d",
                 nm, h, o_flags, o_cyc, o_ins, o_stl, o_run, exp_to, ec, ei, es, exp_run[s]);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_m = 0; start_s = 0; start_a = 0; hlt = 0; retire = 0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (o_flags !== 4'b1000 || o_cyc !== 16'd0 || o_ins !== 16'd0 || o_stl !== 16'd0 || o_run !== 8'd0) begin
        n_fail++;
        $display("FAIL reset inst=%0d: flags=%b cyc=%0d ins=%0d stl=%0d run=%0d, required flags=1000 all 0",
                 s, o_flags, o_cyc, o_ins, o_stl, o_run);
      end
    end
    tick();
    rst = 1'b1;
    sel = 0;
    tick(); tick();
    n_checks++;
    if (o_flags !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_no_start: flags=%b, required 1000", o_flags);
    end
  endtask

  task automatic test_timeout();
    run_once("timeout", 0, 20, 16, 0, 1);
  endtask

  task automatic test_halt();
    run_once("halt", 0, 20, 16, 7, 2);
  endtask

  task automatic test_hlt_priority();
    run_once("hlt_priority", 0, 20, 16, 20, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_once("random", 0, 20, 16, int'($urandom_range(1, 30)), 3);
  endtask

  task automatic test_saturation();
    run_once("saturation", 1, 0, 4, 31, 1);
    run_once("saturation_rand", 1, 0, 4, int'($urandom_range(10, 40)), 3);
  endtask

  task automatic test_back_to_back();
    int ins;
    sel = 2;
    hlt = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int run = 1; run <= 3; run++) begin
      ins = 0;
      for (int r = 1; r <= RST_N; r++) begin
        n_checks++;
        if (o_flags !== 4'b1000 || o_cyc !== 16'd0) begin
          n_fail++;
          $display("FAIL auto_reset run=%0d r=%0d: flags=%b cyc=%0d, required flags=1000 cyc=0",
                   run, r, o_flags, o_cyc);
        end
        tick();
      end
      for (int k = 1; k <= 20; k++) begin
        n_checks++;
        if (o_flags !== 4'b0100) begin
          n_fail++;
          $display("FAIL auto_run run=%0d k=%0d: flags=%b, required 0100", run, k, o_flags);
        end
        retire = 1'($urandom_range(0, 1));
        ins += int'(retire);
        tick();
      end
      retire = 1'b0;
      n_checks++;
      if (o_flags !== 4'b1011 || o_cyc !== 16'd20 || o_ins !== 16'(ins) || o_run !== 8'(run)) begin
        n_fail++;
        $display("FAIL auto_done run=%0d: flags=%b cyc=%0d ins=%0d run_cnt=%0d, required flags=1011 cyc=20 ins=%0d run_cnt=%0d",
                 run, o_flags, o_cyc, o_ins, o_run, ins, run);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    sel = 0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < RST_N + 4; i++) begin
      retire = 1'b1;
      tick();
    end
    n_checks++;
    if (o_flags !== 4'b0100 || o_cyc !== 16'd4 || o_ins !== 16'd4) begin
      n_fail++;
      $display("FAIL pre_abort: flags=%b cyc=%0d ins=%0d, required flags=0100 cyc=4 ins=4", o_flags, o_cyc, o_ins);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_flags !== 4'b1000 || o_cyc !== 16'd0 || o_ins !== 16'd0 || o_stl !== 16'd0 || o_run !== 8'd0) begin
      n_fail++;
      $display("FAIL async_abort: flags=%b cyc=%0d ins=%0d stl=%0d run=%0d, required flags=1000 all 0",
               o_flags, o_cyc, o_ins, o_stl, o_run);
    end
    retire = 1'b0;
    for (int s = 0; s < 3; s++) exp_run[s] = 0;
    tick();
    rst = 1'b1;
    tick();
    run_once("after_abort", 0, 20, 16, 5, 3);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) exp_run[s] = 0;
    test_reset();
    test_timeout();
    test_halt();
    test_hlt_priority();
    test_random();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
